// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared immediate-format codes and default datapath width for the msrv32 decode stage
package msrv32_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_I1  = 3'b001;
  localparam logic [2:0] IMM_S   = 3'b010;
  localparam logic [2:0] IMM_B   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_J   = 3'b101;
  localparam logic [2:0] IMM_CSR = 3'b110;
  localparam logic [2:0] IMM_I7  = 3'b111;
  localparam logic [2:0] RVC_CI  = 3'b000;
  localparam logic [2:0] RVC_CL  = 3'b001;
  localparam logic [2:0] RVC_CJ  = 3'b010;
  localparam logic [2:0] RVC_CB  = 3'b011;
endpackage

// File: rtl/msrv32_imm_decode.sv
// msrv32_imm_decode: combinational immediate format mux, instruction word + format code -> XLEN immediate
//   instr_i    32-bit instruction word
//   imm_type_i format code (msrv32_pkg IMM_* / RVC_* codes)
//   rvc_i      instr_i[15:0] is compressed (only with MSRV32_IMM_RVC_EN defined)
//   imm_o      immediate sign-extended to XLEN
module msrv32_imm_decode
  import msrv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      imm_type_i,
`ifdef MSRV32_IMM_RVC_EN
  input  logic            rvc_i,
`endif
  output logic [XLEN-1:0] imm_o
);
  logic        s;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, csr_imm, std32, imm32;
  logic        unused_ok;
  assign s       = instr_i[31];
  assign i_imm   = {{20{s}}, instr_i[31:20]};
  assign s_imm   = {{20{s}}, instr_i[31:25], instr_i[11:7]};
  assign b_imm   = {{19{s}}, s, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign u_imm   = {instr_i[31:12], 12'h000};
  assign j_imm   = {{11{s}}, s, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign csr_imm = {27'd0, instr_i[19:15]};
  assign std32   = (imm_type_i == IMM_S)   ? s_imm   :
                   (imm_type_i == IMM_B)   ? b_imm   :
                   (imm_type_i == IMM_U)   ? u_imm   :
                   (imm_type_i == IMM_J)   ? j_imm   :
                   (imm_type_i == IMM_CSR) ? csr_imm : i_imm;
`ifdef MSRV32_IMM_RVC_EN
  logic [31:0] ci_imm, cl_imm, cj_imm, cb_imm, c32;
  assign ci_imm = {{26{instr_i[12]}}, instr_i[12], instr_i[6:2]};
  assign cl_imm = {25'd0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00};
  assign cj_imm = {{20{instr_i[12]}}, instr_i[12], instr_i[8], instr_i[10:9], instr_i[6],
                   instr_i[7], instr_i[2], instr_i[11], instr_i[5:3], 1'b0};
  assign cb_imm = {{23{instr_i[12]}}, instr_i[12], instr_i[6:5], instr_i[2], instr_i[11:10],
                   instr_i[4:3], 1'b0};
  assign c32    = (imm_type_i == RVC_CI) ? ci_imm :
                  (imm_type_i == RVC_CL) ? cl_imm :
                  (imm_type_i == RVC_CJ) ? cj_imm :
                  (imm_type_i == RVC_CB) ? cb_imm : 32'd0;
  assign imm32  = rvc_i ? c32 : std32;
`else
  assign imm32  = std32;
`endif
  // The opcode size bits never contribute to an immediate.
  assign unused_ok = ^instr_i[1:0];
  // Every 32-bit format is already correctly signed at bit 31 (CSR/CL have a zero there),
  // so a single sign extension to XLEN covers all formats, including U on RV64.
  assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/msrv32_imm_gen_pipe.sv
// msrv32_imm_gen_pipe: pipelined immediate generator, decode -> output register + 1-entry skid, valid/ready both sides
//   clk_in/rst_n_in        clock, asynchronous active-low reset
//   flush_in               drops all buffered entries (dominates accept and transfer)
//   valid_in/ready_out     upstream handshake; ready_out is purely registered
//   instr_in/imm_type_in   instruction word and immediate format code
//   tag_in                 sideband carried with the entry
//   rvc_in                 compressed-format select, present only with MSRV32_IMM_RVC_EN defined
//   valid_out/ready_in     downstream handshake
//   imm_out/tag_out        extended immediate and its sideband
module msrv32_imm_gen_pipe
  import msrv32_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [31:0]      instr_in,
  input  logic [2:0]       imm_type_in,
  input  logic [TAG_W-1:0] tag_in,
`ifdef MSRV32_IMM_RVC_EN
  input  logic             rvc_in,
`endif
  output logic             valid_out,
  input  logic             ready_in,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] tag_out
);
  logic [XLEN-1:0]  dec_imm;
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [XLEN-1:0]  main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
  logic             acc, xfer, load_main, from_skid, new_main, new_skid;
  msrv32_imm_decode #(.XLEN(XLEN)) u_dec (
    .instr_i    (instr_in),
    .imm_type_i (imm_type_in),
`ifdef MSRV32_IMM_RVC_EN
    .rvc_i      (rvc_in),
`endif
    .imm_o      (dec_imm)
  );
  assign ready_out = ~skid_v_q;
  assign valid_out = main_v_q;
  assign imm_out   = main_imm_q;
  assign tag_out   = main_tag_q;
  assign acc       = valid_in & ready_out;
  assign xfer      = main_v_q & ready_in;
  // Main frees up when empty or draining; the skid is only ever full while main is full,
  // and a full skid blocks acceptance, so skid->main and input->main never collide.
  assign load_main = ~main_v_q | xfer;
  assign from_skid = ~flush_in & load_main & skid_v_q;
  assign new_main  = ~flush_in & load_main & ~skid_v_q & acc;
  assign new_skid  = ~flush_in & ~load_main & acc;
  always_comb begin
    main_v_d   = flush_in ? 1'b0 : load_main ? (skid_v_q | acc) : 1'b1;
    skid_v_d   = flush_in ? 1'b0 : skid_v_q ? ~xfer : new_skid;
    main_imm_d = from_skid ? skid_imm_q : new_main ? dec_imm : main_imm_q;
    main_tag_d = from_skid ? skid_tag_q : new_main ? tag_in : main_tag_q;
    skid_imm_d = new_skid ? dec_imm : skid_imm_q;
    skid_tag_d = new_skid ? tag_in : skid_tag_q;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      main_imm_q <= '0;
      main_tag_q <= '0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
    end else begin
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      main_imm_q <= main_imm_d;
      main_tag_q <= main_tag_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
    end
  end
endmodule

// File: tb/tb_msrv32_imm_gen_pipe.sv
// tb_msrv32_imm_gen_pipe: directed vector table plus hand-written handshake, flush and reset sequences
module tb_msrv32_imm_gen_pipe;
  logic        clk_in = 1'b0;
  logic        rst_n_in, flush_in, valid_in, ready_in, rvc_in;
  logic [31:0] instr_in;
  logic [2:0]  imm_type_in;
  logic [7:0]  tag_in;
  logic        ready_out, valid_out, ready64, valid64;
  logic [31:0] imm_out;
  logic [63:0] imm64;
  logic [7:0]  tag_out, tag64;
  int checks = 0;
  int errors = 0;
  always #5 clk_in = ~clk_in;
  msrv32_imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in), .valid_in(valid_in),
    .ready_out(ready_out), .instr_in(instr_in), .imm_type_in(imm_type_in), .tag_in(tag_in),
`ifdef MSRV32_IMM_RVC_EN
    .rvc_in(rvc_in),
`endif
    .valid_out(valid_out), .ready_in(ready_in), .imm_out(imm_out), .tag_out(tag_out)
  );
  msrv32_imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in), .valid_in(valid_in),
    .ready_out(ready64), .instr_in(instr_in), .imm_type_in(imm_type_in), .tag_in(tag_in),
`ifdef MSRV32_IMM_RVC_EN
    .rvc_in(rvc_in),
`endif
    .valid_out(valid64), .ready_in(ready_in), .imm_out(imm64), .tag_out(tag64)
  );
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  typ;
    logic        rvc;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];
  logic [39:0] q[$];
  logic        held_v;
  logic [31:0] held_imm;
  logic [7:0]  held_tag;
  int nxt, got, cyc;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1; rvc_in = 1'b0;
    instr_in = '0; imm_type_in = '0; tag_in = '0;
    vecs.push_back('{32'hFFF00093, 3'b000, 1'b0, 32'hFFFFFFFF});
    vecs.push_back('{32'hFE000EE3, 3'b011, 1'b0, 32'hFFFFFFFC});
    vecs.push_back('{32'h800000EF, 3'b101, 1'b0, 32'hFFF00000});
    vecs.push_back('{32'h800002B7, 3'b100, 1'b0, 32'h80000000});
    vecs.push_back('{32'h12345037, 3'b100, 1'b0, 32'h12345000});
    vecs.push_back('{32'h00500093, 3'b001, 1'b0, 32'h00000005});
    vecs.push_back('{32'h7FF00093, 3'b111, 1'b0, 32'h000007FF});
    vecs.push_back('{32'h80000000, 3'b000, 1'b0, 32'hFFFFF800});
    vecs.push_back('{32'hFE000C23, 3'b010, 1'b0, 32'hFFFFFFF8});
    vecs.push_back('{32'h00000463, 3'b011, 1'b0, 32'h00000008});
    vecs.push_back('{32'h0080006F, 3'b101, 1'b0, 32'h00000008});
    vecs.push_back('{32'h800F8000, 3'b110, 1'b0, 32'h0000001F});
`ifdef MSRV32_IMM_RVC_EN
    vecs.push_back('{32'h0000BFFD, 3'b010, 1'b1, 32'hFFFFFFFE});
    vecs.push_back('{32'h0000107C, 3'b000, 1'b1, 32'hFFFFFFFF});
    vecs.push_back('{32'h00000014, 3'b000, 1'b1, 32'h00000005});
    vecs.push_back('{32'h00001C60, 3'b001, 1'b1, 32'h0000007C});
    vecs.push_back('{32'h00001C7C, 3'b011, 1'b1, 32'hFFFFFFFE});
    vecs.push_back('{32'hFFFFBFFD, 3'b100, 1'b1, 32'h00000000});
`endif
    repeat (2) @(negedge clk_in);
    chk("rst_valid", valid_out, 0);
    chk("rst_imm", imm_out, 0);
    chk("rst_tag", tag_out, 0);
    chk("rst_ready", ready_out, 1);
    chk("rst_ready64", ready64, 1);
    rst_n_in = 1'b1;
    tick;
    for (int k = 0; k < vecs.size(); k++) begin
      instr_in = vecs[k].instr; imm_type_in = vecs[k].typ; rvc_in = vecs[k].rvc;
      tag_in = 8'(k + 1); valid_in = 1'b1; ready_in = 1'b1;
      tick;
      chk("vec_valid", valid_out, 1);
      chk("vec_imm", imm_out, vecs[k].exp);
      chk("vec_tag", tag_out, 8'(k + 1));
      chk("vec_imm64", imm64, {{32{vecs[k].exp[31]}}, vecs[k].exp});
      chk("vec_tag64", tag64, 8'(k + 1));
    end
    valid_in = 1'b0; rvc_in = 1'b0; imm_type_in = 3'b000;
    tick;
    chk("drain_valid", valid_out, 0);
    chk("drain_valid64", valid64, 0);
    nxt = 1; got = 0; cyc = 0; held_v = 1'b0; held_imm = '0; held_tag = '0;
    while (got < 6 && cyc < 40) begin
      cyc++;
      ready_in = !(cyc >= 3 && cyc <= 5);
      valid_in = (nxt <= 6);
      tag_in = 8'(nxt);
      instr_in = {12'(nxt * 17), 20'h00093};
      if (cyc == 3) chk("bp_ready_c3", ready_out, 1);
      if (cyc == 4) chk("bp_ready_c4", ready_out, 0);
      if (cyc == 6) chk("bp_ready_c6", ready_out, 0);
      if (cyc == 7) chk("bp_ready_c7", ready_out, 1);
      if (held_v) begin
        chk("bp_hold_valid", valid_out, 1);
        chk("bp_hold_imm", imm_out, held_imm);
        chk("bp_hold_tag", tag_out, held_tag);
      end
      held_v = valid_out & ~ready_in; held_imm = imm_out; held_tag = tag_out;
      if (valid_out && ready_in) begin
        if (q.size() == 0) chk("bp_extra_entry", 1, 0);
        else begin
          chk("bp_tag", tag_out, q[0][7:0]);
          chk("bp_imm", imm_out, q[0][39:8]);
          void'(q.pop_front());
        end
        got++;
      end
      if (valid_in && ready_out) begin
        q.push_back({32'(nxt * 17), 8'(nxt)});
        nxt++;
      end
      tick;
    end
    valid_in = 1'b0;
    chk("bp_count", got, 6);
    chk("bp_sent", nxt, 7);
    chk("bp_queue_empty", q.size(), 0);
    ready_in = 1'b0; valid_in = 1'b1;
    tag_in = 8'h10; instr_in = 32'h12300093; tick;
    tag_in = 8'h11; instr_in = 32'h45600093; tick;
    chk("fl_full_ready", ready_out, 0);
    chk("fl_full_valid", valid_out, 1);
    flush_in = 1'b1; ready_in = 1'b1; tag_in = 8'h12; instr_in = 32'h78900093; tick;
    flush_in = 1'b0; valid_in = 1'b0;
    chk("fl_valid", valid_out, 0);
    chk("fl_ready", ready_out, 1);
    chk("fl_imm_hold", imm_out, 32'h00000123);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("fl_stay_empty", valid_out, 0);
    end
    ready_in = 1'b0; valid_in = 1'b1; tag_in = 8'h20; instr_in = 32'h00100093; tick;
    chk("fl2_main_valid", valid_out, 1);
    chk("fl2_ready", ready_out, 1);
    flush_in = 1'b1; tag_in = 8'h21; instr_in = 32'h00200093; tick;
    flush_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    chk("fl2_valid", valid_out, 0);
    chk("fl2_ready_after", ready_out, 1);
    tick;
    chk("fl2_no_ghost", valid_out, 0);
    valid_in = 1'b1; tag_in = 8'h30; instr_in = 32'h03000093; tick;
    valid_in = 1'b0;
    chk("post_fl_valid", valid_out, 1);
    chk("post_fl_tag", tag_out, 8'h30);
    chk("post_fl_imm", imm_out, 32'h00000030);
    ready_in = 1'b0; valid_in = 1'b1;
    tag_in = 8'h40; instr_in = 32'h04000093; tick;
    tag_in = 8'h41; instr_in = 32'h04100093; tick;
    valid_in = 1'b0;
    chk("mr_pre_ready", ready_out, 0);
    #2 rst_n_in = 1'b0;
    #1;
    chk("mr_valid", valid_out, 0);
    chk("mr_imm", imm_out, 0);
    chk("mr_tag", tag_out, 0);
    chk("mr_ready", ready_out, 1);
    chk("mr_imm64", imm64, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1; ready_in = 1'b1;
    tick;
    chk("mr_after_valid", valid_out, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
